// File: rtl/gyro_spi3w_responder_if.sv
`default_nettype none
//==============================================================================
// gyro_spi3w_responder_if : 3-wire SPI pins plus write/frame event outputs.
// Rev 1.0
//==============================================================================
interface gyro_spi3w_responder_if;
    logic       SPI_SCK;
    logic       SPI_CS;
    logic       SPI_D_IN;
    logic       SPI_D_OUT;
    logic       SPI_D_OE;
    logic       wr_stb;
    logic [6:0] wr_addr;
    logic [7:0] wr_data;
    logic       frame_done;
    logic       frame_err;

    modport master (
        output SPI_SCK, SPI_CS, SPI_D_IN,
        input  SPI_D_OUT, SPI_D_OE, wr_stb, wr_addr, wr_data, frame_done, frame_err
    );

    modport slave (
        input  SPI_SCK, SPI_CS, SPI_D_IN,
        output SPI_D_OUT, SPI_D_OE, wr_stb, wr_addr, wr_data, frame_done, frame_err
    );
endinterface
`default_nettype wire

// File: rtl/gyro_spi3w_responder.sv
`default_nettype none
//==============================================================================
// gyro_spi3w_responder : oversampling 3-wire SPI responder serving a register file.
// Optional SCK-stall abort: define GYRO_SPI3W_TIMEOUT_EN.            Rev 1.0
//==============================================================================
module gyro_spi3w_responder #(
    parameter int         NUM_REGS    = 16,
    parameter logic [7:0] ID_VALUE    = 8'hD4,
    parameter int         SYNC_STAGES = 2,
    parameter int         TIMEOUT_CYC = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    gyro_spi3w_responder_if.slave     spi_bus,
    output logic [8*NUM_REGS-1:0]     regs_o
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CMD     = 3'd1;
    localparam logic [2:0] RDATA   = 3'd2;
    localparam logic [2:0] WDATA   = 3'd3;
    localparam logic [2:0] DONE    = 3'd4;
`ifdef GYRO_SPI3W_TIMEOUT_EN
    localparam logic [2:0] WAIT_CS = 3'd5;
`endif

    if (NUM_REGS < 1 || NUM_REGS > 128 || SYNC_STAGES < 2 ||
        TIMEOUT_CYC < 2 || TIMEOUT_CYC > 65535) begin : g_param_check
        $error("gyro_spi3w_responder: parameter out of range");
    end

    logic [SYNC_STAGES-1:0] sck_sync_q, cs_sync_q, din_sync_q;
    logic                   sck_prev_q, cs_prev_q;
    logic                   w_sck, w_cs, w_din;
    logic                   w_sck_rise, w_sck_fall, w_cs_rise, w_cs_fall;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sck_sync_q <= '0;
            cs_sync_q  <= '1;
            din_sync_q <= '0;
            sck_prev_q <= 1'b0;
            cs_prev_q  <= 1'b1;
        end else begin
            sck_sync_q <= {sck_sync_q[SYNC_STAGES-2:0], spi_bus.SPI_SCK};
            cs_sync_q  <= {cs_sync_q[SYNC_STAGES-2:0], spi_bus.SPI_CS};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], spi_bus.SPI_D_IN};
            sck_prev_q <= sck_sync_q[SYNC_STAGES-1];
            cs_prev_q  <= cs_sync_q[SYNC_STAGES-1];
        end
    end

    assign w_sck      = sck_sync_q[SYNC_STAGES-1];
    assign w_cs       = cs_sync_q[SYNC_STAGES-1];
    assign w_din      = din_sync_q[SYNC_STAGES-1];
    assign w_sck_rise =  w_sck & ~sck_prev_q;
    assign w_sck_fall = ~w_sck &  sck_prev_q;
    assign w_cs_rise  =  w_cs  & ~cs_prev_q;
    assign w_cs_fall  = ~w_cs  &  cs_prev_q;

    logic [2:0] state_q, state_d;
    logic [3:0] bitcnt_q, bitcnt_d;
    logic [6:0] sin_q, sin_d;
    logic [7:0] sout_q, sout_d;
    logic [6:0] addr_q, addr_d;
    logic       bad_q, bad_d;
    logic       dout_q, dout_d, oe_q, oe_d;
    logic       pend_q, pend_d;
    logic [6:0] wr_addr_q, wr_addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_stb_q, wr_stb_d, fdone_q, fdone_d, ferr_q, ferr_d;
    logic [7:0] regs_q [NUM_REGS];

    logic [6:0] w_cmd_addr;
    logic       w_addr_ok;
    logic [7:0] w_rd_val;
    logic       w_active, w_timeout;

    assign w_cmd_addr = {sin_q[5:0], w_din};
    assign w_addr_ok  = 32'(w_cmd_addr) < 32'(NUM_REGS);
    assign w_active   = (state_q == CMD) || (state_q == RDATA) || (state_q == WDATA);

    always_comb begin
        w_rd_val = 8'h00;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (w_cmd_addr == 7'(i)) w_rd_val = regs_q[i];
        end
    end

`ifdef GYRO_SPI3W_TIMEOUT_EN
    logic [15:0] idle_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                       idle_cnt_q <= '0;
        else if (!w_active || w_sck_rise || w_sck_fall) idle_cnt_q <= '0;
        else                                           idle_cnt_q <= idle_cnt_q + 16'd1;
    end

    assign w_timeout = w_active && (idle_cnt_q == 16'(TIMEOUT_CYC));
`else
    assign w_timeout = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        bitcnt_d  = bitcnt_q;
        sin_d     = sin_q;
        sout_d    = sout_q;
        addr_d    = addr_q;
        bad_d     = bad_q;
        dout_d    = dout_q;
        oe_d      = oe_q;
        pend_d    = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_stb_d  = pend_q;
        fdone_d   = 1'b0;
        ferr_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_cs_fall) begin
                    state_d  = CMD;
                    bitcnt_d = 4'd0;
                    bad_d    = 1'b0;
                end
            end
            CMD, RDATA, WDATA: begin
                if (w_cs_rise || w_timeout) begin
`ifdef GYRO_SPI3W_TIMEOUT_EN
                    state_d = w_cs_rise ? IDLE : WAIT_CS;
`else
                    state_d = IDLE;
`endif
                    ferr_d  = 1'b1;
                    oe_d    = 1'b0;
                    dout_d  = 1'b0;
                end else if (w_sck_rise) begin
                    sin_d    = {sin_q[5:0], w_din};
                    bitcnt_d = bitcnt_q + 4'd1;
                    if (state_q == CMD && bitcnt_q == 4'd7) begin
                        addr_d = w_cmd_addr;
                        bad_d  = !w_addr_ok;
                        if (sin_q[6]) begin
                            state_d = RDATA;
                            sout_d  = w_addr_ok ? w_rd_val : 8'h00;
                        end else begin
                            state_d = WDATA;
                        end
                    end else if (bitcnt_q == 4'd15) begin
                        // Counter parks at 15; DONE absorbs any further edges.
                        state_d  = DONE;
                        bitcnt_d = bitcnt_q;
                        if (state_q == WDATA && !bad_q && addr_q != 7'd0) begin
                            pend_d    = 1'b1;
                            wr_addr_d = addr_q;
                            wr_data_d = {sin_q, w_din};
                        end
                    end
                end else if (w_sck_fall && state_q == RDATA) begin
                    dout_d = sout_q[7];
                    sout_d = {sout_q[6:0], 1'b0};
                    oe_d   = 1'b1;
                end
            end
            DONE: begin
                if (w_cs_rise) begin
                    state_d = IDLE;
                    fdone_d = 1'b1;
                    ferr_d  = bad_q;
                    oe_d    = 1'b0;
                    dout_d  = 1'b0;
                end
            end
`ifdef GYRO_SPI3W_TIMEOUT_EN
            WAIT_CS: begin
                if (w_cs_rise) state_d = IDLE;
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            bitcnt_q  <= '0;
            sin_q     <= '0;
            sout_q    <= '0;
            addr_q    <= '0;
            bad_q     <= 1'b0;
            dout_q    <= 1'b0;
            oe_q      <= 1'b0;
            pend_q    <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_stb_q  <= 1'b0;
            fdone_q   <= 1'b0;
            ferr_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bitcnt_q  <= bitcnt_d;
            sin_q     <= sin_d;
            sout_q    <= sout_d;
            addr_q    <= addr_d;
            bad_q     <= bad_d;
            dout_q    <= dout_d;
            oe_q      <= oe_d;
            pend_q    <= pend_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_stb_q  <= wr_stb_d;
            fdone_q   <= fdone_d;
            ferr_q    <= ferr_d;
        end
    end

    // Register 0 is the read-only ID; only 1..NUM_REGS-1 accept writes.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= (i == 0) ? ID_VALUE : 8'h00;
        end else begin
            for (int i = 1; i < NUM_REGS; i++) begin
                if (pend_q && wr_addr_q == 7'(i)) regs_q[i] <= wr_data_q;
            end
        end
    end

    for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_regs_out
        assign regs_o[8*gi +: 8] = regs_q[gi];
    end

    assign spi_bus.SPI_D_OUT  = dout_q;
    assign spi_bus.SPI_D_OE   = oe_q;
    assign spi_bus.wr_stb     = wr_stb_q;
    assign spi_bus.wr_addr    = wr_addr_q;
    assign spi_bus.wr_data    = wr_data_q;
    assign spi_bus.frame_done = fdone_q;
    assign spi_bus.frame_err  = ferr_q;

endmodule
`default_nettype wire

// File: tb/tb_gyro_spi3w_responder.sv
`default_nettype none
//==============================================================================
// tb_gyro_spi3w_responder : directed SPI master with scoreboard-checked events.
// Rev 1.0
//==============================================================================
module tb_gyro_spi3w_responder;

    localparam int K_WR = 0;
    localparam int K_FR = 1;
    localparam int K_RD = 2;

    typedef struct {
        int         kind;
        logic [6:0] addr;
        logic [7:0] data;
        logic       done;
        logic       err;
    } exp_t;

    logic         clk;
    logic         rst;
    logic [127:0] regs;
    logic [127:0] exp_regs;
    logic         rd_vld;
    logic [7:0]   rd_byte;
    exp_t         exp_q[$];
    int           errors;
    int           checks;

    gyro_spi3w_responder_if spi_if ();

    gyro_spi3w_responder #(
        .NUM_REGS    (16),
        .ID_VALUE    (8'hD4),
        .SYNC_STAGES (2),
        .TIMEOUT_CYC (64)
    ) u_dut (
        .clk     (clk),
        .rst     (rst),
        .spi_bus (spi_if),
        .regs_o  (regs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time (got timeout, required finish)");
        $fatal(1);
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp_v);
        end
    endtask

    task automatic push(input int kind, input logic [6:0] a, input logic [7:0] d,
                        input logic dn, input logic er);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.done = dn; e.err = er;
        exp_q.push_back(e);
    endtask

    task automatic sb_pop(input int kind, input logic [6:0] a, input logic [7:0] d,
                          input logic dn, input logic er);
        exp_t e;
        bit   ok;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL sb_unexpected: got kind=%0d addr=%h data=%h done=%b err=%b, required no event",
                     kind, a, d, dn, er);
        end else begin
            e = exp_q.pop_front();
            ok = (e.kind == kind);
            if (ok && kind == K_WR) ok = (e.addr == a) && (e.data == d);
            if (ok && kind == K_RD) ok = (e.data == d);
            if (ok && kind == K_FR) ok = (e.done == dn) && (e.err == er);
            if (!ok) begin
                errors++;
                $display("FAIL sb_event: got kind=%0d addr=%h data=%h done=%b err=%b, required kind=%0d addr=%h data=%h done=%b err=%b",
                         kind, a, d, dn, er, e.kind, e.addr, e.data, e.done, e.err);
            end
        end
    endtask

    // Monitor: every DUT-presented event is matched against the expected queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (spi_if.wr_stb) sb_pop(K_WR, spi_if.wr_addr, spi_if.wr_data, 1'b0, 1'b0);
            if (rd_vld)        sb_pop(K_RD, 7'd0, rd_byte, 1'b0, 1'b0);
            if (spi_if.frame_done || spi_if.frame_err)
                sb_pop(K_FR, 7'd0, 8'd0, spi_if.frame_done, spi_if.frame_err);
        end
    end

    task automatic half();
        repeat (8) @(posedge clk);
        #1;
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic spi_frame(input logic [15:0] f, input int nbits, input bit raise_cs);
        logic [7:0] rx;
        rx = 8'h00;
        spi_if.SPI_CS = 1'b0;
        half();
        for (int i = 0; i < nbits; i++) begin
            spi_if.SPI_D_IN = f[15 - i];
            half();
            if (i == 7) check("oe_low_in_cmd", 128'(spi_if.SPI_D_OE), 128'd0);
            if (f[15] && i == 8) check("oe_at_first_rd_bit", 128'(spi_if.SPI_D_OE), 128'd1);
            if (i >= 8) rx = {rx[6:0], spi_if.SPI_D_OUT};
            spi_if.SPI_SCK = 1'b1;
            half();
            spi_if.SPI_SCK = 1'b0;
        end
        if (f[15] && nbits == 16) begin
            rd_byte = rx;
            rd_vld  = 1'b1;
            @(posedge clk);
            #1;
            rd_vld  = 1'b0;
        end
        half();
        if (f[15] && nbits == 16) check("oe_held_until_cs", 128'(spi_if.SPI_D_OE), 128'd1);
        if (raise_cs) begin
            spi_if.SPI_CS = 1'b1;
            gap(6);
            check("oe_released", 128'(spi_if.SPI_D_OE), 128'd0);
        end
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        rd_vld = 1'b0;
        rd_byte = 8'h00;
        spi_if.SPI_CS = 1'b1;
        spi_if.SPI_SCK = 1'b0;
        spi_if.SPI_D_IN = 1'b0;
        exp_regs = '0;
        exp_regs[7:0] = 8'hD4;
        gap(4);
        rst = 1'b0;
        @(negedge clk);
        check("rst_regs",       regs, exp_regs);
        check("rst_oe",         128'(spi_if.SPI_D_OE), 128'd0);
        check("rst_dout",       128'(spi_if.SPI_D_OUT), 128'd0);
        check("rst_wr_stb",     128'(spi_if.wr_stb), 128'd0);
        check("rst_wr_addr",    128'(spi_if.wr_addr), 128'd0);
        check("rst_wr_data",    128'(spi_if.wr_data), 128'd0);
        check("rst_frame_done", 128'(spi_if.frame_done), 128'd0);
        check("rst_frame_err",  128'(spi_if.frame_err), 128'd0);
        gap(16);

        // write reg3 = 5A
        push(K_WR, 7'd3, 8'h5A, 1'b0, 1'b0); push(K_FR, 7'd0, 8'd0, 1'b1, 1'b0);
        spi_frame(16'h035A, 16, 1'b1);
        exp_regs[31:24] = 8'h5A;
        check("regs_after_wr3", regs, exp_regs);
        gap(32);

        // read ID register
        push(K_RD, 7'd0, 8'hD4, 1'b0, 1'b0); push(K_FR, 7'd0, 8'd0, 1'b1, 1'b0);
        spi_frame(16'h8000, 16, 1'b1);
        gap(32);

        // write reg7 = C3 then back-to-back read
        push(K_WR, 7'd7, 8'hC3, 1'b0, 1'b0); push(K_FR, 7'd0, 8'd0, 1'b1, 1'b0);
        spi_frame(16'h07C3, 16, 1'b1);
        exp_regs[63:56] = 8'hC3;
        gap(26);
        push(K_RD, 7'd0, 8'hC3, 1'b0, 1'b0); push(K_FR, 7'd0, 8'd0, 1'b1, 1'b0);
        spi_frame(16'h8700, 16, 1'b1);
        check("regs_after_wr7", regs, exp_regs);
        gap(32);

        // bad-address read and write
        push(K_RD, 7'd0, 8'h00, 1'b0, 1'b0); push(K_FR, 7'd0, 8'd0, 1'b1, 1'b1);
        spi_frame(16'hA000, 16, 1'b1);
        gap(32);
        push(K_FR, 7'd0, 8'd0, 1'b1, 1'b1);
        spi_frame(16'h20AB, 16, 1'b1);
        check("regs_after_bad_wr", regs, exp_regs);
        gap(32);

        // write to read-only register 0
        push(K_FR, 7'd0, 8'd0, 1'b1, 1'b0);
        spi_frame(16'h0055, 16, 1'b1);
        check("regs_after_wr0", regs, exp_regs);
        gap(32);

        // highest valid address
        push(K_WR, 7'd15, 8'h99, 1'b0, 1'b0); push(K_FR, 7'd0, 8'd0, 1'b1, 1'b0);
        spi_frame(16'h0F99, 16, 1'b1);
        exp_regs[127:120] = 8'h99;
        check("regs_after_wr15", regs, exp_regs);
        gap(32);
        push(K_RD, 7'd0, 8'h99, 1'b0, 1'b0); push(K_FR, 7'd0, 8'd0, 1'b1, 1'b0);
        spi_frame(16'h8F00, 16, 1'b1);
        gap(32);

        // abort after 11 bits of a write to reg2
        push(K_FR, 7'd0, 8'd0, 1'b0, 1'b1);
        spi_frame(16'h0277, 11, 1'b1);
        check("regs_after_abort", regs, exp_regs);
        gap(32);

`ifdef GYRO_SPI3W_TIMEOUT_EN
        // SCK stalls after 5 bits; later edges ignored until CS toggles
        push(K_FR, 7'd0, 8'd0, 1'b0, 1'b1);
        spi_frame(16'h0311, 5, 1'b0);
        gap(100);
        repeat (4) begin
            spi_if.SPI_SCK = 1'b1; half();
            spi_if.SPI_SCK = 1'b0; half();
        end
        spi_if.SPI_CS = 1'b1;
        gap(32);
        push(K_WR, 7'd4, 8'h66, 1'b0, 1'b0); push(K_FR, 7'd0, 8'd0, 1'b1, 1'b0);
        spi_frame(16'h0466, 16, 1'b1);
        exp_regs[39:32] = 8'h66;
        check("regs_after_timeout", regs, exp_regs);
        gap(32);
`endif

        // reset in the middle of a read
        spi_frame(16'h8300, 10, 1'b0);
        check("oe_mid_read", 128'(spi_if.SPI_D_OE), 128'd1);
        rst = 1'b1;
        #1;
        check("oe_async_rst", 128'(spi_if.SPI_D_OE), 128'd0);
        exp_regs = '0;
        exp_regs[7:0] = 8'hD4;
        check("regs_async_rst", regs, exp_regs);
        spi_if.SPI_CS = 1'b1;
        spi_if.SPI_SCK = 1'b0;
        gap(4);
        rst = 1'b0;
        gap(32);
        push(K_RD, 7'd0, 8'hD4, 1'b0, 1'b0); push(K_FR, 7'd0, 8'd0, 1'b1, 1'b0);
        spi_frame(16'h8000, 16, 1'b1);

        gap(40);
        check("scoreboard_drained", 128'(exp_q.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
